// File: rtl/ft_fault_campaign_pkg.sv
// Shared types for the fault-campaign controller: FSM state encoding and schedule entry layout.
package ft_fault_campaign_pkg;

    localparam int unsigned DEF_NUM_CH = 2;
    localparam int unsigned DEF_CNT_W  = 32;
    localparam int unsigned DEF_LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_END   = 2'd3
    } state_e;

    // Field widths follow the default controller configuration; the top casts at the boundary.
    typedef struct packed {
        logic [DEF_CNT_W-1:0]  cycle;
        logic [DEF_NUM_CH-1:0] mask;
        logic [DEF_LEN_W-1:0]  len;
    } event_t;

endpackage

// File: rtl/ft_pulse_gen.sv
// Per-channel error pulse generator: loadable down-counter where a new load only extends the pulse.
module ft_pulse_gen
    import ft_fault_campaign_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             active_o
);

    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] rem;
    logic             active_q;

    // A load competes with what would remain after this cycle's decrement, so overlaps extend, never add.
    always_comb begin
        rem   = (cnt_q != '0) ? cnt_q - LEN_W'(1) : '0;
        cnt_d = rem;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i && (len_i > rem)) begin
            cnt_d = len_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= (cnt_d != '0);
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/ft_fault_campaign_ctrl.sv
// Fault-campaign controller: sequences SoC reset/fetch enable, fires scheduled error pulses,
// and reports pass or watchdog timeout.
module ft_fault_campaign_ctrl
    import ft_fault_campaign_pkg::*;
#(
    parameter int unsigned NUM_CH       = DEF_NUM_CH,
    parameter int unsigned NUM_EVENTS   = 4,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned LEN_W        = DEF_LEN_W,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic                            ev_we_i,
    input  logic [$clog2(NUM_EVENTS)-1:0]   ev_idx_i,
    input  logic [CNT_W-1:0]                ev_cycle_i,
    input  logic [NUM_CH-1:0]               ev_mask_i,
    input  logic [LEN_W-1:0]                ev_len_i,
    input  logic [CNT_W-1:0]                timeout_i,
    input  logic                            done_i,
    output logic                            core_rst_no,
    output logic                            fetch_enable_o,
    output logic [NUM_CH-1:0]               error_o,
    output logic                            busy_o,
    output logic                            pass_o,
    output logic                            timeout_o,
    output logic [CNT_W-1:0]                cycle_o,
    output logic [$clog2(NUM_EVENTS+1)-1:0] inj_count_o
);

    localparam int unsigned IDX_W  = $clog2(NUM_EVENTS);
    localparam int unsigned ICNT_W = $clog2(NUM_EVENTS + 1);
    localparam int unsigned RC_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_e              st_q, st_d;
    logic [RC_W-1:0]     rcnt_q, rcnt_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [ICNT_W-1:0]   inj_q, inj_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;
    logic [NUM_EVENTS-1:0] fired_q, fired_d;
    event_t              ev_q [NUM_EVENTS];
    event_t              ev_d [NUM_EVENTS];

    logic                core_rst_n_q, fetch_q, busy_q;

    logic [NUM_EVENTS-1:0] fire;
    logic [ICNT_W-1:0]   fire_cnt;
    logic [NUM_CH-1:0]   load;
    logic [LEN_W-1:0]    load_len [NUM_CH];
    logic [NUM_CH-1:0]   pulse_active;
    logic                pulse_clr;

    // Entry match: at most once per run, and never at or beyond the watchdog limit.
    always_comb begin
        fire     = '0;
        fire_cnt = '0;
        for (int e = 0; e < NUM_EVENTS; e++) begin
            if ((st_q == ST_RUN) && !fired_q[e] && (ev_q[e].len != '0) &&
                (CNT_W'(ev_q[e].cycle) == cycle_q) &&
                (CNT_W'(ev_q[e].cycle) < timeout_i)) begin
                fire[e]  = 1'b1;
                fire_cnt = fire_cnt + ICNT_W'(1);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            load[c]     = 1'b0;
            load_len[c] = '0;
            for (int e = 0; e < NUM_EVENTS; e++) begin
                if (fire[e] && ev_q[e].mask[c]) begin
                    load[c] = 1'b1;
                    if (LEN_W'(ev_q[e].len) > load_len[c]) begin
                        load_len[c] = LEN_W'(ev_q[e].len);
                    end
                end
            end
        end
    end

    always_comb begin
        st_d      = st_q;
        rcnt_d    = rcnt_q;
        cycle_d   = cycle_q;
        inj_d     = inj_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        fired_d   = fired_q;
        ev_d      = ev_q;

        unique case (st_q)
            ST_IDLE, ST_END: begin
                if (start_i) begin
                    st_d = ST_RESET;
                end
            end
            ST_RESET: begin
                if (rcnt_q == RC_W'(RESET_CYCLES - 1)) begin
                    st_d = ST_RUN;
                end else begin
                    rcnt_d = rcnt_q + RC_W'(1);
                end
            end
            ST_RUN: begin
                fired_d = fired_q | fire;
                inj_d   = inj_q + fire_cnt;
                // done_i outranks a coincident watchdog expiry.
                if (done_i) begin
                    pass_d = 1'b1;
                    st_d   = ST_END;
                end else if (cycle_q == timeout_i) begin
                    timeout_d = 1'b1;
                    st_d      = ST_END;
                end else if (cycle_q != '1) begin
                    cycle_d = cycle_q + CNT_W'(1);
                end
            end
            default: st_d = ST_IDLE;
        endcase

        if ((st_d == ST_RESET) && (st_q != ST_RESET)) begin
            rcnt_d    = '0;
            cycle_d   = '0;
            inj_d     = '0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            fired_d   = '0;
        end

        if (ev_we_i && ((st_q == ST_IDLE) || (st_q == ST_END))) begin
            for (int e = 0; e < NUM_EVENTS; e++) begin
                if (ev_idx_i == IDX_W'(e)) begin
                    ev_d[e].cycle = DEF_CNT_W'(ev_cycle_i);
                    ev_d[e].mask  = DEF_NUM_CH'(ev_mask_i);
                    ev_d[e].len   = DEF_LEN_W'(ev_len_i);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q         <= ST_IDLE;
            rcnt_q       <= '0;
            cycle_q      <= '0;
            inj_q        <= '0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fired_q      <= '0;
            core_rst_n_q <= 1'b0;
            fetch_q      <= 1'b0;
            busy_q       <= 1'b0;
            for (int e = 0; e < NUM_EVENTS; e++) begin
                ev_q[e] <= '0;
            end
        end else begin
            st_q         <= st_d;
            rcnt_q       <= rcnt_d;
            cycle_q      <= cycle_d;
            inj_q        <= inj_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            fired_q      <= fired_d;
            // Core reset stays released in END so the SoC state remains inspectable.
            core_rst_n_q <= (st_d == ST_RUN) || (st_d == ST_END);
            fetch_q      <= (st_d == ST_RUN);
            busy_q       <= (st_d == ST_RESET) || (st_d == ST_RUN);
            for (int e = 0; e < NUM_EVENTS; e++) begin
                ev_q[e] <= ev_d[e];
            end
        end
    end

    // Pulses only live in RUN; leaving it (including via done/timeout) truncates them at once.
    assign pulse_clr = (st_d != ST_RUN);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ft_pulse_gen #(
            .LEN_W (LEN_W)
        ) u_pulse (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clr_i    (pulse_clr),
            .load_i   (load[c]),
            .len_i    (load_len[c]),
            .active_o (pulse_active[c])
        );
    end

    assign core_rst_no    = core_rst_n_q;
    assign fetch_enable_o = fetch_q;
    assign error_o        = pulse_active;
    assign busy_o         = busy_q;
    assign pass_o         = pass_q;
    assign timeout_o      = timeout_q;
    assign cycle_o        = cycle_q;
    assign inj_count_o    = inj_q;

endmodule

// File: tb/tb_ft_fault_campaign_ctrl.sv
// Bench for ft_fault_campaign_ctrl: directed and randomized campaigns against an interval-based model.
module tb_ft_fault_campaign_ctrl;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        ev_we_i = 1'b0;
    logic [1:0]  ev_idx_i = '0;
    logic [31:0] ev_cycle_i = '0;
    logic [1:0]  ev_mask_i = '0;
    logic [7:0]  ev_len_i = '0;
    logic [31:0] timeout_i = '0;
    logic        done_i = 1'b0;

    logic        core_rst_no, fetch_enable_o, busy_o, pass_o, timeout_o;
    logic [1:0]  error_o;
    logic [31:0] cycle_o;
    logic [2:0]  inj_count_o;

    int total = 0;
    int bad = 0;

    // Model of the schedule as written by the bench.
    int m_cyc [4];
    int m_mask[4];
    int m_len [4];

    ft_fault_campaign_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .ev_we_i        (ev_we_i),
        .ev_idx_i       (ev_idx_i),
        .ev_cycle_i     (ev_cycle_i),
        .ev_mask_i      (ev_mask_i),
        .ev_len_i       (ev_len_i),
        .timeout_i      (timeout_i),
        .done_i         (done_i),
        .core_rst_no    (core_rst_no),
        .fetch_enable_o (fetch_enable_o),
        .error_o        (error_o),
        .busy_o         (busy_o),
        .pass_o         (pass_o),
        .timeout_o      (timeout_o),
        .cycle_o        (cycle_o),
        .inj_count_o    (inj_count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A channel is high at RUN cycle j if any entry that fires covers j with its window k+1..k+len.
    function automatic int exp_err(int j, int tmo);
        int r = 0;
        for (int e = 0; e < 4; e++) begin
            if (m_len[e] != 0 && m_cyc[e] < tmo && m_cyc[e] < j && j <= m_cyc[e] + m_len[e])
                r = r | m_mask[e];
        end
        return r;
    endfunction

    function automatic int exp_inj(int tmo, int t_end);
        int n = 0;
        for (int e = 0; e < 4; e++) begin
            if (m_len[e] != 0 && m_cyc[e] < tmo && m_cyc[e] <= t_end) n++;
        end
        return n;
    endfunction

    task automatic wr_ev(input int idx, input int cyc, input int mask, input int len);
        ev_we_i    = 1'b1;
        ev_idx_i   = 2'(idx);
        ev_cycle_i = 32'(cyc);
        ev_mask_i  = 2'(mask);
        ev_len_i   = 8'(len);
        @(posedge clk); #1;
        ev_we_i = 1'b0;
        m_cyc[idx]  = cyc;
        m_mask[idx] = mask;
        m_len[idx]  = len;
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_core_rst"}, core_rst_no, 0);
        chk({pfx, "_fetch"}, fetch_enable_o, 0);
        chk({pfx, "_error"}, error_o, 0);
        chk({pfx, "_busy"}, busy_o, 0);
        chk({pfx, "_pass"}, pass_o, 0);
        chk({pfx, "_timeout"}, timeout_o, 0);
        chk({pfx, "_cycle"}, cycle_o, 0);
        chk({pfx, "_inj"}, inj_count_o, 0);
    endtask

    // One full campaign; done_at < 0 means done_i is never raised.
    task automatic run(input int tmo, input int done_at, input bit noise);
        bit passed;
        int t_end;
        passed = (done_at >= 0) && (done_at <= tmo);
        t_end  = passed ? done_at : tmo;
        timeout_i = 32'(tmo);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int r = 0; r < R; r++) begin
            chk($sformatf("rst_busy@%0d", r), busy_o, 1);
            chk($sformatf("rst_core@%0d", r), core_rst_no, 0);
            chk($sformatf("rst_fetch@%0d", r), fetch_enable_o, 0);
            @(posedge clk); #1;
        end
        for (int j = 0; j <= t_end; j++) begin
            chk($sformatf("run_cycle@%0d", j), cycle_o, 64'(j));
            chk($sformatf("run_err@%0d", j), error_o, 64'(exp_err(j, tmo)));
            chk($sformatf("run_fetch@%0d", j), fetch_enable_o, 1);
            chk($sformatf("run_core@%0d", j), core_rst_no, 1);
            chk($sformatf("run_busy@%0d", j), busy_o, 1);
            done_i = (j == done_at);
            if (noise && j == 3) begin
                start_i    = 1'b1;
                ev_we_i    = 1'b1;
                ev_idx_i   = 2'd0;
                ev_cycle_i = 32'd5;
                ev_mask_i  = 2'b11;
                ev_len_i   = 8'd7;
            end
            @(posedge clk); #1;
            done_i  = 1'b0;
            start_i = 1'b0;
            ev_we_i = 1'b0;
        end
        chk("end_pass", pass_o, 64'(passed));
        chk("end_timeout", timeout_o, 64'(!passed));
        chk("end_busy", busy_o, 0);
        chk("end_error", error_o, 0);
        chk("end_fetch", fetch_enable_o, 0);
        chk("end_core", core_rst_no, 1);
        chk("end_cycle", cycle_o, 64'(t_end));
        chk("end_inj", inj_count_o, 64'(exp_inj(tmo, t_end)));
        repeat (2) @(posedge clk);
        #1;
        chk("end_frozen_cycle", cycle_o, 64'(t_end));
        chk("end_hold_error", error_o, 0);
        chk("end_hold_core", core_rst_no, 1);
    endtask

    initial begin
        for (int e = 0; e < 4; e++) begin
            m_cyc[e] = 0; m_mask[e] = 0; m_len[e] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        rst_ni = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy_o, 0);

        // Basic run without entries, pass at RUN cycle 60
        run(1000, 60, 1'b0);

        // Two single-channel entries on different channels
        wr_ev(0, 18, 1, 2);
        wr_ev(1, 78, 2, 2);
        run(200, 90, 1'b0);

        // Overlap extension on ch0 plus same-cycle combining
        wr_ev(0, 10, 1, 5);
        wr_ev(1, 12, 1, 2);
        wr_ev(2, 30, 1, 3);
        wr_ev(3, 30, 3, 1);
        run(200, 40, 1'b0);

        // Watchdog expiry; entry beyond the limit never fires
        wr_ev(0, 150, 1, 3);
        wr_ev(1, 0, 0, 0);
        wr_ev(2, 0, 0, 0);
        wr_ev(3, 0, 0, 0);
        run(100, -1, 1'b0);

        // done_i coinciding with the watchdog limit
        run(50, 50, 1'b0);

        // Truncation by done_i, with a start and schedule write attempted during RUN
        wr_ev(0, 15, 1, 10);
        run(200, 20, 1'b1);
        run(200, 40, 1'b0);

        // Randomized campaigns restarted from END
        for (int n = 0; n < 8; n++) begin
            int tmo;
            int da;
            for (int e = 0; e < 4; e++)
                wr_ev(e, int'($urandom_range(0, 120)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 8)));
            tmo = int'($urandom_range(30, 130));
            da  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(5, 150));
            run(tmo, da, n[0]);
        end

        // Asynchronous reset mid-RUN drops everything, including the schedule
        wr_ev(0, 5, 1, 3);
        timeout_i = 32'd200;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (R + 10) @(posedge clk);
        #1;
        chk("pre_rst_cycle", cycle_o, 10);
        chk("pre_rst_busy", busy_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_values("async");
        for (int e = 0; e < 4; e++) begin
            m_cyc[e] = 0; m_mask[e] = 0; m_len[e] = 0;
        end
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        run(40, 30, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ft_fault_campaign_ctrl.md
# ft_fault_campaign_ctrl

Synthesisable fault-campaign controller for the fault-tolerant SoC. It sequences the core reset and fetch enable, then drives error-injection pulses on up to NUM_CH fault channels from a programmable schedule of NUM_EVENTS entries. It watches a completion flag with a cycle watchdog and reports pass or timeout. It sits beside the SoC top, on the same clock, and replaces hard-coded bench timing with a reusable, multi-channel, multi-event engine.

## Interface
- NUM_CH, 2: number of independent error outputs (cores/lanes)
- NUM_EVENTS, 4: schedule entries
- CNT_W, 32: cycle counter / event time width
- LEN_W, 8: pulse length width (cycles)
- RESET_CYCLES, 4: cycles the core reset is held after start
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  launch a campaign (single-cycle pulse)
- ev_we_i  in  1  schedule write strobe
- ev_idx_i  in  $clog2(NUM_EVENTS)  entry written
- ev_cycle_i  in  CNT_W  injection cycle, relative to first RUN cycle
- ev_mask_i  in  NUM_CH  channels hit by the entry
- ev_len_i  in  LEN_W  pulse length; 0 disables the entry
- timeout_i  in  CNT_W  watchdog limit in RUN cycles
- done_i  in  1  completion flag from the SoC (e.g. data memory flag word non-zero)
- core_rst_no  out  1  reset to the SoC, active low
- fetch_enable_o  out  1  core fetch enable
- error_o  out  NUM_CH  error injection lines
- busy_o  out  1  campaign in RESET or RUN
- pass_o  out  1  sticky: done_i seen before timeout
- timeout_o  out  1  sticky: watchdog expired
- cycle_o  out  CNT_W  current RUN cycle count
- inj_count_o  out  $clog2(NUM_EVENTS+1)  entries fired this run

## Operation
- FSM states: IDLE, RESET, RUN, END.
- IDLE -> RESET on start_i. RESET -> RUN after RESET_CYCLES cycles. RUN -> END on done_i or when cycle_o == timeout_i. END -> RESET on start_i.
- start_i is ignored in RESET and RUN.
- Schedule writes are accepted only in IDLE and END and are ignored otherwise. Entries persist across runs. All entries are cleared (len 0) by rst_ni.
- Entering RESET clears pass_o, timeout_o, cycle_o, inj_count_o, and all per-entry fired bits.
- RUN:
  - cycle_o increments every cycle, starting at 0.
  - An entry fires once, when cycle_o == ev_cycle and len != 0.
  - On a fire, each masked channel's pulse counter loads max(remaining, len). Overlapping pulses extend; they do not add.
  - Several entries firing in the same cycle combine: masks are ORed and the largest len wins per channel.
  - inj_count_o adds the number of entries fired in that cycle.
  - error_o[c] = (pulse counter[c] != 0). Counters decrement each RUN cycle.
- Terminal priority: done_i and timeout in the same cycle give pass_o=1, timeout_o=0.
- END: error_o forced 0 and counters cleared; fetch_enable_o=0; core_rst_no stays 1 so memory/state remain inspectable; cycle_o frozen.
- Entries whose ev_cycle >= timeout_i never fire.
- cycle_o saturates at all-ones.

## Timing
- All outputs are registered.
- Reset values: core_rst_no=0, fetch_enable_o=0, error_o=0, busy_o=0, pass_o=0, timeout_o=0, cycle_o=0, inj_count_o=0. The FSM resets to IDLE.
- start_i sampled at edge t: busy_o=1 and core_rst_no=0 from t+1 through t+RESET_CYCLES.
- At t+RESET_CYCLES+1: core_rst_no=1, fetch_enable_o=1, cycle_o=0.
- Event with ev_cycle=k, len=L: error_o high during RUN cycles k+1 .. k+L, i.e. one cycle after the match, for exactly L cycles.
- done_i sampled high at RUN cycle n: from the next cycle, state is END, pass_o=1, busy_o=0, and error_o=0 (pulses are truncated).
- rst_ni asserted mid-run: all outputs return to reset values immediately (asynchronous), and the schedule is lost.

## Structure
- Package ft_fault_campaign_pkg holds:
  - the state enum (IDLE/RESET/RUN/END);
  - the event_t struct (cycle, mask, len);
  - a default LEN_W constant.
- Sub-module ft_pulse_gen, one instance per channel:
  - loadable down-counter implementing max-extend semantics;
  - synchronous clear;
  - output: active flag.

## Test plan
- Basic run (NUM_CH=2, RESET_CYCLES=4): start_i at cycle 0 -> core_rst_no low cycles 1-4, fetch_enable_o high from cycle 5. done_i at RUN cycle 60 -> pass_o=1, busy_o=0, timeout_o=0.
- Two entries, {18, mask 01, len 2} and {78, mask 10, len 2} -> error_o=01 at RUN cycles 19-20 and error_o=10 at RUN cycles 79-80. inj_count_o=2.
- Overlap on ch0, {10, len 5} and {12, len 2} -> error_o[0] high at cycles 11-15 only. Same-cycle entries {30, mask 01, len 3} and {30, mask 11, len 1} -> ch0 high 31-33, ch1 high 31 only.
- Watchdog: timeout_i=100, done_i never asserted -> timeout_o=1 after RUN cycle 100, cycle_o frozen at 100. An entry at cycle 150 never fires. done_i and timeout in the same cycle -> pass_o=1.
- Pulse truncation: done_i at RUN cycle 20 during a len-10 pulse started at cycle 15 -> error_o=0 from the next cycle. Schedule write attempted during RUN -> entry unchanged on the rerun.
- Restart and reset: start_i from END -> statuses cleared and entries fire again. rst_ni pulsed low mid-RUN -> all outputs at reset values at once, and a following run with no schedule writes produces no pulses.
